// File: rtl/equivalence_stream_comparator_if.sv
// Handshake bundle for the stream comparator: two input streams joined word by word,
// plus one result stream.
interface equivalence_stream_comparator_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 a_vld, a_rdy;
  logic [WIDTH-1:0]     a_dat;
  logic                 b_vld, b_rdy;
  logic [WIDTH-1:0]     b_dat;
  logic                 o_vld, o_rdy, o_eq;
  logic [CNT_WIDTH-1:0] o_idx;

  modport master (
    output a_vld, a_dat, b_vld, b_dat, o_rdy,
    input  a_rdy, b_rdy, o_vld, o_eq, o_idx
  );

  modport slave (
    input  a_vld, a_dat, b_vld, b_dat, o_rdy,
    output a_rdy, b_rdy, o_vld, o_eq, o_idx
  );
endinterface

// File: rtl/equivalence_stream_comparator.sv
// Joins streams A and B, emits one registered equality result per pair, and keeps
// saturating match/miss statistics plus a capture of the first mismatching pair.
module equivalence_stream_comparator #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  equivalence_stream_comparator_if.slave io,
  output logic [CNT_WIDTH-1:0] cnt_match,
  output logic [CNT_WIDTH-1:0] cnt_miss,
  output logic                 miss_flg,
  output logic [CNT_WIDTH-1:0] miss_idx,
  output logic [WIDTH-1:0]     miss_a,
  output logic [WIDTH-1:0]     miss_b
);

  logic                 o_vld_q, o_vld_d;
  logic                 o_eq_q, o_eq_d;
  logic [CNT_WIDTH-1:0] o_idx_q, o_idx_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_WIDTH-1:0] cnt_match_q, cnt_match_d;
  logic [CNT_WIDTH-1:0] cnt_miss_q, cnt_miss_d;
  logic                 miss_flg_q, miss_flg_d;
  logic [CNT_WIDTH-1:0] miss_idx_q, miss_idx_d;
  logic [WIDTH-1:0]     miss_a_q, miss_a_d;
  logic [WIDTH-1:0]     miss_b_q, miss_b_d;

  logic free, xfer, eq;

  // Each ready looks only at the other side's valid, so neither stream can wait on itself.
  assign free     = !o_vld_q || io.o_rdy;
  assign io.a_rdy = io.b_vld && free;
  assign io.b_rdy = io.a_vld && free;
  assign xfer     = io.a_vld && io.b_vld && free;
  assign eq       = (io.a_dat == io.b_dat);

  always_comb begin
    o_vld_d     = o_vld_q;
    o_eq_d      = o_eq_q;
    o_idx_d     = o_idx_q;
    idx_d       = idx_q;
    cnt_match_d = cnt_match_q;
    cnt_miss_d  = cnt_miss_q;
    miss_flg_d  = miss_flg_q;
    miss_idx_d  = miss_idx_q;
    miss_a_d    = miss_a_q;
    miss_b_d    = miss_b_q;

    if (free) begin
      o_vld_d = xfer;
      if (xfer) begin
        o_eq_d  = eq;
        o_idx_d = idx_q;
      end
    end

    // clr wins over statistics, but a pair taken this cycle is still forwarded above.
    if (clr) begin
      idx_d       = '0;
      cnt_match_d = '0;
      cnt_miss_d  = '0;
      miss_flg_d  = 1'b0;
      miss_idx_d  = '0;
      miss_a_d    = '0;
      miss_b_d    = '0;
    end else if (xfer) begin
      idx_d = idx_q + 1'b1;
      if (eq) begin
        if (cnt_match_q != '1) cnt_match_d = cnt_match_q + 1'b1;
      end else begin
        if (cnt_miss_q != '1) cnt_miss_d = cnt_miss_q + 1'b1;
        if (!miss_flg_q) begin
          miss_flg_d = 1'b1;
          miss_idx_d = idx_q;
          miss_a_d   = io.a_dat;
          miss_b_d   = io.b_dat;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld_q     <= 1'b0;
      o_eq_q      <= 1'b0;
      o_idx_q     <= '0;
      idx_q       <= '0;
      cnt_match_q <= '0;
      cnt_miss_q  <= '0;
      miss_flg_q  <= 1'b0;
      miss_idx_q  <= '0;
      miss_a_q    <= '0;
      miss_b_q    <= '0;
    end else begin
      o_vld_q     <= o_vld_d;
      o_eq_q      <= o_eq_d;
      o_idx_q     <= o_idx_d;
      idx_q       <= idx_d;
      cnt_match_q <= cnt_match_d;
      cnt_miss_q  <= cnt_miss_d;
      miss_flg_q  <= miss_flg_d;
      miss_idx_q  <= miss_idx_d;
      miss_a_q    <= miss_a_d;
      miss_b_q    <= miss_b_d;
    end
  end

  assign io.o_vld  = o_vld_q;
  assign io.o_eq   = o_eq_q;
  assign io.o_idx  = o_idx_q;
  assign cnt_match = cnt_match_q;
  assign cnt_miss  = cnt_miss_q;
  assign miss_flg  = miss_flg_q;
  assign miss_idx  = miss_idx_q;
  assign miss_a    = miss_a_q;
  assign miss_b    = miss_b_q;

endmodule

// File: tb/tb_equivalence_stream_comparator.sv
// Directed bench: a 32/16 instance for the main scenarios and a 32/4 instance for
// index wrap and counter saturation.
module tb_equivalence_stream_comparator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic clr4 = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  equivalence_stream_comparator_if #(.WIDTH(32), .CNT_WIDTH(16)) sif ();
  equivalence_stream_comparator_if #(.WIDTH(32), .CNT_WIDTH(4))  sif4 ();

  logic [15:0] cnt_match, cnt_miss, miss_idx;
  logic        miss_flg;
  logic [31:0] miss_a, miss_b;
  logic [3:0]  cnt_match4, cnt_miss4, miss_idx4;
  logic        miss_flg4;
  logic [31:0] miss_a4, miss_b4;

  equivalence_stream_comparator #(.WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .io(sif),
    .cnt_match(cnt_match), .cnt_miss(cnt_miss), .miss_flg(miss_flg),
    .miss_idx(miss_idx), .miss_a(miss_a), .miss_b(miss_b)
  );

  equivalence_stream_comparator #(.WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr4), .io(sif4),
    .cnt_match(cnt_match4), .cnt_miss(cnt_miss4), .miss_flg(miss_flg4),
    .miss_idx(miss_idx4), .miss_a(miss_a4), .miss_b(miss_b4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic bv, input logic [31:0] ad, input logic [31:0] bd);
    sif.a_vld = av; sif.b_vld = bv; sif.a_dat = ad; sif.b_dat = bd;
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    sif.o_rdy = 1'b1;
    sif4.a_vld = 1'b0; sif4.b_vld = 1'b0; sif4.a_dat = 32'h0; sif4.b_dat = 32'h0; sif4.o_rdy = 1'b1;

    // reset state; readies follow the join condition while held in reset
    #1;
    chk("rst_o_vld", sif.o_vld, 0);
    chk("rst_cnt_match", cnt_match, 0);
    chk("rst_miss_flg", miss_flg, 0);
    chk("rst_a_rdy", sif.a_rdy, 0);
    chk("rst_b_rdy", sif.b_rdy, 1);
    #11 rst_n = 1'b1;

    // three equal pairs back to back
    drive(1'b1, 1'b1, 5, 5);
    tick(); chk("eq0_vld", sif.o_vld, 1); chk("eq0_eq", sif.o_eq, 1); chk("eq0_idx", sif.o_idx, 0);
    drive(1'b1, 1'b1, 7, 7);
    tick(); chk("eq1_vld", sif.o_vld, 1); chk("eq1_idx", sif.o_idx, 1);
    drive(1'b1, 1'b1, 9, 9);
    tick(); chk("eq2_vld", sif.o_vld, 1); chk("eq2_idx", sif.o_idx, 2); chk("eq2_match", cnt_match, 3);
    drive(1'b0, 1'b0, 0, 0);
    tick(); chk("eq_idle_vld", sif.o_vld, 0); chk("eq_miss", cnt_miss, 0); chk("eq_flg", miss_flg, 0);

    // clear, then mixed pairs with first-mismatch capture
    clr = 1'b1;
    tick(); clr = 1'b0;
    chk("clr_match", cnt_match, 0);
    drive(1'b1, 1'b1, 1, 1);
    tick(); chk("mx0_eq", sif.o_eq, 1); chk("mx0_idx", sif.o_idx, 0);
    drive(1'b1, 1'b1, 2, 32'hFF);
    tick(); chk("mx1_eq", sif.o_eq, 0); chk("mx1_flg", miss_flg, 1); chk("mx1_midx", miss_idx, 1);
    chk("mx1_ma", miss_a, 2); chk("mx1_mb", miss_b, 32'hFF);
    drive(1'b1, 1'b1, 3, 3);
    tick(); chk("mx2_eq", sif.o_eq, 1);
    drive(1'b1, 1'b1, 4, 32'h10);
    tick(); chk("mx3_eq", sif.o_eq, 0); chk("mx3_idx", sif.o_idx, 3); chk("mx3_miss", cnt_miss, 2);
    chk("mx3_match", cnt_match, 2); chk("mx3_midx", miss_idx, 1); chk("mx3_ma", miss_a, 2); chk("mx3_mb", miss_b, 32'hFF);

    // A valid alone never transfers
    drive(1'b1, 1'b0, 32'h55, 32'h55);
    tick(); chk("ab_a_rdy", sif.a_rdy, 0); chk("ab_b_rdy", sif.b_rdy, 1);
    for (int i = 0; i < 4; i++) begin
      chk("ab_no_vld", sif.o_vld, 0);
      tick();
    end
    chk("ab_idle_idx_hold", sif.o_vld, 0);
    sif.b_vld = 1'b1;
    #1 chk("ab_a_rdy_join", sif.a_rdy, 1);
    tick(); chk("ab_vld", sif.o_vld, 1); chk("ab_idx", sif.o_idx, 4); chk("ab_match", cnt_match, 3);
    drive(1'b0, 1'b0, 0, 0);
    tick();

    // backpressure: one pair accepted, output held, readies low
    sif.o_rdy = 1'b0;
    drive(1'b1, 1'b1, 32'h66, 32'h66);
    tick(); chk("bp_vld", sif.o_vld, 1); chk("bp_idx", sif.o_idx, 5);
    drive(1'b1, 1'b1, 32'h70, 32'h71);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_vld", sif.o_vld, 1); chk("bp_hold_idx", sif.o_idx, 5); chk("bp_hold_eq", sif.o_eq, 1);
      chk("bp_a_rdy", sif.a_rdy, 0); chk("bp_b_rdy", sif.b_rdy, 0); chk("bp_match", cnt_match, 4);
    end
    sif.o_rdy = 1'b1;
    #1 chk("bp_release_rdy", sif.a_rdy, 1);
    tick(); chk("bp_next_idx", sif.o_idx, 6); chk("bp_next_eq", sif.o_eq, 0);
    chk("bp_next_miss", cnt_miss, 3); chk("bp_first_kept", miss_idx, 1);
    drive(1'b0, 1'b0, 0, 0);
    tick(); chk("bp_drain", sif.o_vld, 0);

    // clr coincident with a mismatching transfer
    clr = 1'b1;
    drive(1'b1, 1'b1, 32'hA, 32'hB);
    tick(); clr = 1'b0;
    chk("cx_vld", sif.o_vld, 1); chk("cx_eq", sif.o_eq, 0); chk("cx_idx", sif.o_idx, 7);
    chk("cx_match", cnt_match, 0); chk("cx_miss", cnt_miss, 0); chk("cx_flg", miss_flg, 0);
    chk("cx_midx", miss_idx, 0); chk("cx_ma", miss_a, 0); chk("cx_mb", miss_b, 0);
    drive(1'b1, 1'b1, 32'hC, 32'hC);
    tick(); chk("cx_next_idx", sif.o_idx, 0); chk("cx_next_match", cnt_match, 1);
    drive(1'b0, 1'b0, 0, 0);
    tick();

    // small counters: index wraps, match count saturates
    sif4.a_vld = 1'b1; sif4.b_vld = 1'b1; sif4.a_dat = 32'h3C; sif4.b_dat = 32'h3C;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("sat_idx", sif4.o_idx, i % 16);
      chk("sat_match", cnt_match4, (i + 1 > 15) ? 15 : i + 1);
    end
    sif4.a_vld = 1'b0; sif4.b_vld = 1'b0;
    tick(); chk("sat_miss", cnt_miss4, 0);

    // asynchronous reset while a result is held
    sif.o_rdy = 1'b0;
    drive(1'b1, 1'b1, 32'h1, 32'h2);
    tick(); chk("ar_vld_pre", sif.o_vld, 1); chk("ar_flg_pre", miss_flg, 1);
    drive(1'b0, 1'b0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("ar_vld", sif.o_vld, 0); chk("ar_match", cnt_match, 0); chk("ar_miss", cnt_miss, 0);
    chk("ar_flg", miss_flg, 0); chk("ar_midx", miss_idx, 0); chk("ar_ma", miss_a, 0);
    #1 rst_n = 1'b1;
    sif.o_rdy = 1'b1;
    drive(1'b1, 1'b1, 32'h9, 32'h9);
    tick(); chk("ar_post_idx", sif.o_idx, 0); chk("ar_post_vld", sif.o_vld, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
